// File: rtl/cafe_pkg.sv
// Shared types, defaults and the grading rule for the coffee-bean sort scheduler.
package cafe_pkg;

    localparam int unsigned DefDepth  = 4;
    localparam int unsigned DefTravel = 8;
    localparam int unsigned DefPulse  = 3;

    typedef enum logic [1:0] {
        BAJA  = 2'd0,
        MEDIA = 2'd1,
        ALTA  = 2'd2
    } grade_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFire = 2'd1,
        StPop  = 2'd2
    } state_e;

    // Number of passed sensor checks decides the grade.
    function automatic grade_e grade_of(input logic tamano, input logic peso, input logic color);
        logic [1:0] passes;
        passes = {1'b0, tamano} + {1'b0, peso} + {1'b0, color};
        case (passes)
            2'd3:    return ALTA;
            2'd2:    return MEDIA;
            default: return BAJA;
        endcase
    endfunction

endpackage

// File: rtl/cafe_sort_scheduler_fifo.sv
// In-order queue of beans on the belt; each entry carries its grade and remaining belt ticks.
module sort_fifo
    import cafe_pkg::*;
#(
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned TRAVEL = DefTravel
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  grade_e                  push_grade,
    input  logic                    pop,
    input  logic                    tick,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output grade_e                  head_grade,
    output logic                    head_due
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);
    localparam logic [7:0]    TravelLoad = 8'(TRAVEL);

    grade_e          grade_q [DEPTH];
    logic [7:0]      ticks_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;

    logic do_push, do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_grade = grade_q[rd_ptr_q];
    // A head reaching zero on this tick counts as already due.
    assign head_due   = !empty &&
                        ((ticks_q[rd_ptr_q] == 8'd0) || (tick && ticks_q[rd_ptr_q] == 8'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ticks_q[i] <= 8'd0;
                grade_q[i] <= BAJA;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (tick && ticks_q[i] != 8'd0) begin
                    ticks_q[i] <= ticks_q[i] - 8'd1;
                end
            end
            // The pushed slot is free, so loading TRAVEL overrides its decrement.
            if (do_push) begin
                ticks_q[wr_ptr_q] <= TravelLoad;
                grade_q[wr_ptr_q] <= push_grade;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cafe_sort_scheduler.sv
// Bean sort scheduler: queues graded beans and pulses the matching ejector gate on arrival.
// Optional per-grade ejection counters are built when CAFE_SORT_STATS_EN is defined.
module cafe_sort_scheduler
    import cafe_pkg::*;
#(
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned TRAVEL = DefTravel,
    parameter int unsigned PULSE  = DefPulse
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bean_valid,
    output logic                    bean_ready,
    input  logic                    sensor_tamano,
    input  logic                    sensor_peso,
    input  logic                    sensor_color,
    input  logic                    belt_tick,
    output logic                    gate_baja,
    output logic                    gate_media,
    output logic                    gate_alta,
    output logic                    busy,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  in_transit
`ifdef CAFE_SORT_STATS_EN
    ,
    output logic [7:0]              cnt_baja,
    output logic [7:0]              cnt_media,
    output logic [7:0]              cnt_alta
`endif
);

    localparam logic [3:0] PulseLast = 4'(PULSE - 1);

    state_e     state_q, state_d;
    logic [3:0] pulse_q, pulse_d;
    logic [2:0] gate_q, gate_d;
    logic       overflow_q;

    logic   full, empty, head_due, push, pop;
    grade_e head_grade;

    assign bean_ready = !full;
    assign push       = bean_valid && !full;
    assign pop        = (state_q == StPop);

    sort_fifo #(
        .DEPTH  (DEPTH),
        .TRAVEL (TRAVEL)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_grade (grade_of(sensor_tamano, sensor_peso, sensor_color)),
        .pop        (pop),
        .tick       (belt_tick),
        .full       (full),
        .empty      (empty),
        .count      (in_transit),
        .head_grade (head_grade),
        .head_due   (head_due)
    );

    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        gate_d  = 3'b000;
        unique case (state_q)
            StIdle: begin
                if (head_due) begin
                    state_d = StFire;
                    pulse_d = 4'd0;
                end
            end
            StFire: begin
                if (pulse_q == PulseLast) begin
                    state_d = StPop;
                end else begin
                    pulse_d = pulse_q + 4'd1;
                end
            end
            StPop:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Gate register tracks the FIRE state exactly, so it is high for PULSE cycles.
        if (state_d == StFire) begin
            unique case (head_grade)
                BAJA:    gate_d = 3'b001;
                MEDIA:   gate_d = 3'b010;
                ALTA:    gate_d = 3'b100;
                default: gate_d = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pulse_q    <= 4'd0;
            gate_q     <= 3'b000;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            gate_q  <= gate_d;
            if (bean_valid && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign gate_baja  = gate_q[0];
    assign gate_media = gate_q[1];
    assign gate_alta  = gate_q[2];
    assign overflow   = overflow_q;
    assign busy       = (in_transit != '0) || (state_q != StIdle);

`ifdef CAFE_SORT_STATS_EN
    logic [7:0] cnt_baja_q, cnt_media_q, cnt_alta_q;
    logic       enter_pop;

    assign enter_pop = (state_q == StFire) && (state_d == StPop);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_baja_q  <= 8'd0;
            cnt_media_q <= 8'd0;
            cnt_alta_q  <= 8'd0;
        end else if (enter_pop) begin
            if (head_grade == BAJA && cnt_baja_q != 8'hff) cnt_baja_q <= cnt_baja_q + 8'd1;
            if (head_grade == MEDIA && cnt_media_q != 8'hff) cnt_media_q <= cnt_media_q + 8'd1;
            if (head_grade == ALTA && cnt_alta_q != 8'hff) cnt_alta_q <= cnt_alta_q + 8'd1;
        end
    end

    assign cnt_baja  = cnt_baja_q;
    assign cnt_media = cnt_media_q;
    assign cnt_alta  = cnt_alta_q;
`endif

endmodule

// File: tb/tb_cafe_sort_scheduler.sv
// Directed self-checking bench for cafe_sort_scheduler at DEPTH=4, TRAVEL=8, PULSE=3.
module tb_cafe_sort_scheduler;

    logic       clk = 1'b0;
    logic       reset, bean_valid, bean_ready;
    logic       sensor_tamano, sensor_peso, sensor_color, belt_tick;
    logic       gate_baja, gate_media, gate_alta, busy, overflow;
    logic [2:0] in_transit;
`ifdef CAFE_SORT_STATS_EN
    logic [7:0] cnt_baja, cnt_media, cnt_alta;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cafe_sort_scheduler #(
        .DEPTH  (4),
        .TRAVEL (8),
        .PULSE  (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bean_valid    (bean_valid),
        .bean_ready    (bean_ready),
        .sensor_tamano (sensor_tamano),
        .sensor_peso   (sensor_peso),
        .sensor_color  (sensor_color),
        .belt_tick     (belt_tick),
        .gate_baja     (gate_baja),
        .gate_media    (gate_media),
        .gate_alta     (gate_alta),
        .busy          (busy),
        .overflow      (overflow),
        .in_transit    (in_transit)
`ifdef CAFE_SORT_STATS_EN
        ,
        .cnt_baja      (cnt_baja),
        .cnt_media     (cnt_media),
        .cnt_alta      (cnt_alta)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs driven before step() are consumed at its edge; outputs are read 1ns after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            belt_tick = 1'b1;
            step();
            belt_tick = 1'b0;
            if (i != n - 1) step();
        end
    endtask

    task automatic accept(input logic t, input logic p, input logic c);
        bean_valid    = 1'b1;
        sensor_tamano = t;
        sensor_peso   = p;
        sensor_color  = c;
        step();
        bean_valid    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [2:0] gates();
        return {gate_alta, gate_media, gate_baja};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int media_n, baja_n, media_last, baja_first, overlap;
        reset = 1'b1; bean_valid = 1'b0; belt_tick = 1'b0;
        sensor_tamano = 1'b0; sensor_peso = 1'b0; sensor_color = 1'b0;
        do_reset();

        check_eq("rst_in_transit", 32'(in_transit), 0);
        check_eq("rst_ready", 32'(bean_ready), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
        check_eq("rst_gates", 32'(gates()), 0);

        // Single ALTA bean travels 8 ticks then pulses gate_alta for 3 cycles.
        accept(1'b1, 1'b1, 1'b1);
        check_eq("t1_in_transit", 32'(in_transit), 1);
        check_eq("t1_busy", 32'(busy), 1);
        tick_n(7);
        step();
        check_eq("t1_gates_before", 32'(gates()), 0);
        tick_n(1);
        check_eq("t1_fire_c1", 32'(gates()), 3'b100);
        step();
        check_eq("t1_fire_c2", 32'(gates()), 3'b100);
        step();
        check_eq("t1_fire_c3", 32'(gates()), 3'b100);
        step();
        check_eq("t1_pop_gates", 32'(gates()), 0);
        check_eq("t1_pop_busy", 32'(busy), 1);
        step();
        check_eq("t1_idle_in_transit", 32'(in_transit), 0);
        check_eq("t1_idle_busy", 32'(busy), 0);

        // MEDIA then BAJA two ticks later: ordered, non-overlapping pulses.
        accept(1'b0, 1'b1, 1'b1);
        tick_n(2);
        step();
        accept(1'b1, 1'b0, 1'b0);
        media_n = 0; baja_n = 0; media_last = -1; baja_first = -1; overlap = 0;
        for (int c = 0; c < 80; c++) begin
            belt_tick = (c % 2 == 0);
            step();
            if (gate_media) begin
                media_n++;
                media_last = c;
            end
            if (gate_baja) begin
                baja_n++;
                if (baja_first < 0) baja_first = c;
            end
            if (int'(gate_baja) + int'(gate_media) + int'(gate_alta) > 1) overlap++;
        end
        belt_tick = 1'b0;
        check_eq("t2_media_len", 32'(media_n), 3);
        check_eq("t2_baja_len", 32'(baja_n), 3);
        check_eq("t2_order", 32'(baja_first > media_last), 1);
        check_eq("t2_overlap", 32'(overlap), 0);
        check_eq("t2_in_transit", 32'(in_transit), 0);

        // Five back-to-back beans into a 4-deep queue.
        for (int i = 1; i <= 5; i++) begin
            accept(1'b0, 1'b0, 1'b0);
            if (i <= 4) check_eq("t3_count", 32'(in_transit), 32'(i));
            if (i == 4) begin
                check_eq("t3_ready_full", 32'(bean_ready), 0);
                check_eq("t3_overflow_pre", 32'(overflow), 0);
            end
        end
        check_eq("t3_overflow", 32'(overflow), 1);
        check_eq("t3_hold", 32'(in_transit), 4);
        for (int c = 0; c < 200 && in_transit != 0; c++) begin
            belt_tick = (c % 2 == 0);
            step();
        end
        belt_tick = 1'b0;
        step();
        check_eq("t3_drained", 32'(in_transit), 0);
        check_eq("t3_overflow_sticky", 32'(overflow), 1);
        do_reset();
        check_eq("t3_overflow_cleared", 32'(overflow), 0);

        // Accept coinciding with the tick that fires the head.
        accept(1'b0, 1'b0, 1'b0);
        tick_n(7);
        step();
        bean_valid = 1'b1;
        sensor_tamano = 1'b1; sensor_peso = 1'b1; sensor_color = 1'b1;
        belt_tick = 1'b1;
        step();
        bean_valid = 1'b0;
        belt_tick = 1'b0;
        check_eq("t4_old_fires", 32'(gates()), 3'b001);
        check_eq("t4_in_transit", 32'(in_transit), 2);
        step();
        step();
        step();
        check_eq("t4_pop", 32'(gates()), 0);
        step();
        check_eq("t4_one_left", 32'(in_transit), 1);
        tick_n(7);
        step();
        check_eq("t4_new_not_yet", 32'(gates()), 0);
        tick_n(1);
        check_eq("t4_new_fires_at_8", 32'(gates()), 3'b100);
        repeat (4) step();
        check_eq("t4_empty", 32'(in_transit), 0);

        // Reset during the second FIRE cycle with overflow set.
        for (int i = 0; i < 5; i++) accept(1'b0, 1'b0, 1'b0);
        check_eq("t5_overflow_set", 32'(overflow), 1);
        tick_n(8);
        check_eq("t5_fire_c1", 32'(gates()), 3'b001);
        step();
        check_eq("t5_fire_c2", 32'(gates()), 3'b001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t5_gates", 32'(gates()), 0);
        check_eq("t5_in_transit", 32'(in_transit), 0);
        check_eq("t5_overflow", 32'(overflow), 0);
        check_eq("t5_ready", 32'(bean_ready), 1);
        check_eq("t5_busy", 32'(busy), 0);

`ifdef CAFE_SORT_STATS_EN
        check_eq("st_rst_baja", 32'(cnt_baja), 0);
        for (int i = 0; i < 300; i++) begin
            accept(1'b0, 1'b0, 1'b0);
            belt_tick = 1'b1;
            repeat (8) step();
            belt_tick = 1'b0;
            repeat (5) step();
        end
        check_eq("st_baja_sat", 32'(cnt_baja), 255);
        check_eq("st_media", 32'(cnt_media), 0);
        check_eq("st_alta", 32'(cnt_alta), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cafe_sort_scheduler.md
CAFE_SORT_SCHEDULER -- requirements
Module: cafe_sort_scheduler

Interface
- REQ-001: Parameter DEPTH, default 4: number of beans the scheduler SHALL hold in transit (power of two, 2..16).
- REQ-002: Parameter TRAVEL, default 8: belt ticks from the sensor station to the ejector gates (1..255).
- REQ-003: Parameter PULSE, default 3: clk cycles each gate SHALL stay asserted per ejection (1..15).
- REQ-004: clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: bean_valid  input  1  a bean is at the sensor station and its sensor bits are valid.
- REQ-007: bean_ready  output  1  the scheduler can accept a bean.
- REQ-008: sensor_tamano, sensor_peso, sensor_color  input  1 each  size, weight and colour pass bits, sampled on accept.
- REQ-009: belt_tick  input  1  single-cycle pulse, one per belt advance step.
- REQ-010: gate_baja, gate_media, gate_alta  output  1 each  ejector gate drives, one-hot or all zero.
- REQ-011: busy  output  1  at least one bean is in transit or a gate is firing.
- REQ-012: overflow  output  1  sticky flag: a bean was dropped.
- REQ-013: in_transit  output  $clog2(DEPTH)+1  number of queued beans.

Function
- REQ-014: A bean SHALL be accepted when bean_valid && bean_ready, and bean_ready SHALL be !full. Full SHALL be evaluated before any pop in the same cycle, with no bypass.
- REQ-015: Grade SHALL be decided on accept: 3 sensor bits set gives ALTA, 2 gives MEDIA, 0 or 1 gives BAJA.
- REQ-016: Each accepted bean SHALL be queued in arrival order with grade and a tick counter loaded with TRAVEL.
- REQ-017: On belt_tick, every queued counter SHALL decrement and saturate at 0. A bean accepted in the same cycle SHALL load TRAVEL undecremented.
- REQ-018: The FSM SHALL have three states with these transitions:
  - IDLE: go to FIRE when the head entry exists and its counter is 0 (including a counter reaching 0 this cycle).
  - FIRE: drive the head grade's gate for exactly PULSE cycles, then go to POP.
  - POP: remove the head for one cycle, then return to IDLE.
- REQ-019: Only the head SHALL fire. A later bean whose counter is already 0 SHALL wait for the head to pop and then fire starting the cycle after POP.
- REQ-020: Gates SHALL be registered, with at most one gate high in any cycle and all gates low in IDLE and POP.
- REQ-021: bean_valid while full SHALL drop the bean and set overflow. The queue SHALL be unchanged.
- REQ-022: in_transit SHALL increment on accept, decrement in POP, and hold when both occur in the same cycle.
- REQ-023: busy SHALL equal (in_transit != 0) || (state != IDLE).

Reset
- REQ-024: Reset SHALL set the following:
  - FSM to IDLE and the queue to empty.
  - in_transit=0, bean_ready=1, busy=0, overflow=0.
  - All gates to 0 and all counters to 0.
- REQ-025: Reset mid-FIRE SHALL drop the gate on the next edge and discard all queued beans.
- REQ-026: overflow SHALL clear only on reset.

Configuration
- REQ-027: With CAFE_SORT_STATS_EN defined, the block SHALL add outputs cnt_baja, cnt_media and cnt_alta (8 bits each).
  - Each counter SHALL increment on entering POP for its grade, saturate at 255, and reset to 0.
- REQ-028: Without CAFE_SORT_STATS_EN, these ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
- REQ-029: Package cafe_pkg SHALL hold the following:
  - Grade typedef with BAJA=2'd0, MEDIA=2'd1, ALTA=2'd2.
  - FSM state typedef.
  - Grade-decision function.
  - Default parameter constants.
- REQ-030: Queue storage and pointers SHALL be a sub-module named sort_fifo (push/pop/full/empty/count, per-entry tick decrement); the FSM and gate logic SHALL stay in the top.

Verification
- REQ-031: Single bean, sensors 1/1/1, TRAVEL=8: after the 8th belt_tick, gate_alta SHALL be high for 3 cycles, and busy SHALL be low one cycle after POP.
- REQ-032: Beans with sensors 0/1/1 then 1/0/0, accepted 2 ticks apart: gate_media pulse SHALL come first, then gate_baja, with no overlap.
- REQ-033: Five back-to-back beans, DEPTH=4, no ticks: bean_ready SHALL be low after the 4th accept, overflow=1 after the 5th, and in_transit SHALL hold at 4.
- REQ-034: Accept and belt_tick in the same cycle, with the queued entry at 1: the new bean's counter SHALL equal 8, and the old one SHALL fire.
- REQ-035: Reset asserted in the 2nd FIRE cycle: gates SHALL be 0, in_transit=0, overflow=0, and bean_ready=1 on the next edge.
- REQ-036: With CAFE_SORT_STATS_EN, 300 BAJA ejections SHALL leave cnt_baja=255.
